// File: rtl/usb_rx_packet_buffer.sv
// Packet-level receive FIFO with speculative write, commit and rollback.
// Define USB_RX_PKTBUF_DROP_CNT_EN to add the saturating dropCount output.
module usb_rx_packet_buffer #(
  parameter int DEPTH_BITS = 6
) (
  input  logic       clk48,
  input  logic       rxRST,
  output logic       rxAcceptNewData,
  input  logic       rxDataValid,
  input  logic [7:0] rxData,
  input  logic       rxIsLastByte,
  input  logic       keepPacket,
  output logic       rdValid,
  output logic [7:0] rdData,
  output logic       rdIsLast,
  input  logic       rdAccept,
  output logic       bufFull
`ifdef USB_RX_PKTBUF_DROP_CNT_EN
  ,
  output logic [7:0] dropCount
`endif
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_STORE,
    RX_DISCARD
  } rx_state_t;

  localparam int PW = DEPTH_BITS + 1;

  rx_state_t        state, state_nxt;
  logic [PW-1:0]    rd_ptr, commit_ptr, wr_ptr;
  logic [PW-1:0]    commit_nxt, wr_nxt;
  logic [8:0]       mem [2**DEPTH_BITS];
  logic             mem_we;
  logic [8:0]       mem_wdata;
  logic             drop;
  logic             wr_hs, rd_hs;

  assign rxAcceptNewData = !rxRST;
  assign wr_hs = rxDataValid && rxAcceptNewData;
  assign rdValid = (rd_ptr != commit_ptr);
  assign rd_hs = rdValid && rdAccept;
  assign bufFull = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign rdData   = mem[rd_ptr[DEPTH_BITS-1:0]][7:0];
  assign rdIsLast = mem[rd_ptr[DEPTH_BITS-1:0]][8];

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    mem_we     = 1'b0;
    mem_wdata  = {1'b0, rxData};
    drop       = 1'b0;
    if (wr_hs) begin
      case (state)
        RX_IDLE, RX_STORE: begin
          if (rxIsLastByte) begin
            state_nxt = RX_IDLE;
            if (keepPacket && !bufFull) begin
              mem_we     = 1'b1;
              mem_wdata  = {1'b1, rxData};
              wr_nxt     = wr_ptr + 1'b1;
              commit_nxt = wr_ptr + 1'b1;
            end else begin
              wr_nxt = commit_ptr;
              drop   = 1'b1;
            end
          end else if (bufFull) begin
            // no room left: forget this packet's bytes, swallow the rest
            wr_nxt    = commit_ptr;
            state_nxt = RX_DISCARD;
          end else begin
            mem_we    = 1'b1;
            wr_nxt    = wr_ptr + 1'b1;
            state_nxt = RX_STORE;
          end
        end
        RX_DISCARD: begin
          if (rxIsLastByte) begin
            wr_nxt    = commit_ptr;
            state_nxt = RX_IDLE;
            drop      = 1'b1;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (rxRST) begin
      state      <= RX_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      if (rd_hs) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk48) begin
    if (mem_we) mem[wr_ptr[DEPTH_BITS-1:0]] <= mem_wdata;
  end

`ifdef USB_RX_PKTBUF_DROP_CNT_EN
  always_ff @(posedge clk48) begin
    if (rxRST) dropCount <= '0;
    else if (drop && dropCount != 8'hff) dropCount <= dropCount + 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: doc/usb_rx_packet_buffer.md
# usb_rx_packet_buffer

Packet-level receive FIFO directly downstream of the SIE receive stage, in the clk48 domain. Consumes the byte-wise receive handshake (data, last-byte flag, keep flag) and stores bytes speculatively. On the last byte it either commits the whole packet to the read side or rolls it back, so the backend only ever sees complete, error-free packets. Overflow mid-packet discards that packet without stalling the receiver.

## Interface
- DEPTH_BITS, 6: log2 of entry count; 2^DEPTH_BITS entries of 9 bits (8 data bits plus 1 last flag).

- clk48  in  1  system clock; all logic is on its posedge
- rxRST  in  1  synchronous, active-high reset
- rxAcceptNewData  out  1  ready towards the receive stage
- rxDataValid  in  1  rxData holds a new byte
- rxData  in  8  received byte
- rxIsLastByte  in  1  current byte ends the packet
- keepPacket  in  1  packet error-free; sampled only on the last-byte handshake
- rdValid  out  1  committed byte available
- rdData  out  8  byte at the read pointer
- rdIsLast  out  1  rdData is the last byte of its packet
- rdAccept  in  1  backend consumes rdData
- bufFull  out  1  speculative write pointer minus read pointer equals 2^DEPTH_BITS

## Operation
- Pointers are DEPTH_BITS+1 wide, with the MSB used as a wrap bit: rdPtr, commitPtr, wrPtr. All three reset to 0.
- Write handshake: rxDataValid && rxAcceptNewData.
- Read handshake: rdValid && rdAccept.
- rxAcceptNewData is 0 during the rxRST cycle and 1 otherwise. The block never back-pressures the receiver, because that stage cannot stall.
- States:
  - RX_IDLE: no packet in progress.
  - RX_STORE: packet in progress and stored.
  - RX_DISCARD: packet in progress, overflowed.
- Transitions:
  - RX_IDLE, write handshake, not last: if bufFull, go to RX_DISCARD. Otherwise write mem[wrPtr] = {0, rxData}, increment wrPtr, go to RX_STORE.
  - RX_STORE, write handshake, not last: same as above. On overflow, wrPtr returns to commitPtr and the state goes to RX_DISCARD.
  - Last-byte handshake from RX_IDLE or RX_STORE, with keepPacket=1 and not bufFull: write {1, rxData}, set commitPtr = wrPtr+1, set wrPtr = wrPtr+1, go to RX_IDLE.
  - Last-byte handshake from RX_IDLE or RX_STORE, with keepPacket=0 or bufFull: set wrPtr = commitPtr (rollback), go to RX_IDLE, count a drop.
  - RX_DISCARD: bytes are accepted and ignored. On the last-byte handshake: wrPtr = commitPtr, go to RX_IDLE, count a drop, regardless of keepPacket.
- Read side:
  - rdValid = (rdPtr != commitPtr).
  - rdData and rdIsLast are read combinationally from mem[rdPtr[DEPTH_BITS-1:0]].
  - rdPtr increments on the read handshake.
- bufFull is evaluated against rdPtr using the pointer values before the current edge.
- A read in the same cycle does not free space for that cycle's write.

## Timing
- Reset values:
  - rxAcceptNewData=0 during reset, then 1.
  - rdValid=0, bufFull=0, state RX_IDLE.
  - rdData and rdIsLast are don't-care while rdValid=0.
- Commit latency: a last-byte handshake with a keep in cycle N gives rdValid=1 in cycle N+1, when the buffer was previously empty.
- Uncommitted bytes are never visible on the read side.
- Simultaneous commit and read: both take effect at the same edge. rdValid reflects the new pointers the next cycle.
- Rollback does not touch rdPtr or committed entries.
- Wrap-around: pointer arithmetic is modulo 2^(DEPTH_BITS+1).
  - Full: index bits equal and MSBs differ.
  - Empty: rdPtr == commitPtr.
- rxRST mid-packet or with committed data pending: everything is cleared, and the state returns to RX_IDLE in the next cycle.
- Maximum storable packet length is 2^DEPTH_BITS bytes.

## Configuration
- USB_RX_PKTBUF_DROP_CNT_EN defined:
  - Adds output dropCount (8 bits).
  - dropCount increments on every dropped packet, saturates at 255, and resets to 0 on rxRST.
- USB_RX_PKTBUF_DROP_CNT_EN undefined:
  - No port and no counter.
  - Drop behaviour is otherwise identical.

## Test plan
- Reset, then a 3-byte packet 0xC3, 0x11, 0x22 with last+keep=1: rdValid rises one cycle after the last handshake. The backend then reads 0xC3, 0x11, 0x22, with rdIsLast=1 only on 0x22. After that, rdValid=0.
- A 4-byte packet with keepPacket=0 on the last byte: rdValid stays 0, wrPtr returns to 0, and dropCount=1 (macro on).
- Committed packet A (2 bytes) still unread, then packet B dropped: only A's 2 bytes can be read, and A stays intact.
- DEPTH_BITS=3, 10-byte packet with keep=1: rxAcceptNewData stays 1, the packet is dropped (RX_DISCARD), rdValid=0, and a following 2-byte good packet is read correctly.
- DEPTH_BITS=3, repeated good 3-byte packets while the backend reads continuously for 50 packets: pointers wrap, and every byte matches in order.
- rxRST asserted during byte 2 of a packet while 1 committed packet is pending: next cycle rdValid=0, bufFull=0, and a new packet after reset is received correctly.
